// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 single-bit mux: one-hot grant, encoded select,
// bounded hold under contention, and a registered data bit with a valid flag.
module mux4_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       dout,
  output logic       dout_valid
);

  localparam int unsigned   CW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t        r_state;
  logic [3:0]    r_gnt;
  logic [1:0]    r_sel;
  logic [1:0]    r_ptr;
  logic [CW-1:0] r_cnt;
  logic          r_dout;
  logic          r_dout_valid;

  logic [3:0]    w_mask;
  logic [1:0]    w_idx;
  logic [1:0]    w_win;
  logic          w_found;
  logic          w_owner_req;
  logic          w_cnt_last;
  logic          w_take;

  // Masking with the current grant makes one scan serve both pick(req) from idle
  // and pick(others) while granted, since gnt is zero in idle.
  always_comb begin
    w_mask  = req & ~r_gnt;
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      w_idx = r_ptr + 2'(i);
      if (!w_found && w_mask[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_owner_req = req[r_sel];
    w_cnt_last  = (r_cnt == CNT_LAST);
    w_take      = w_found && ((r_state == S_IDLE) || !w_owner_req || w_cnt_last);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_sel        <= '0;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_dout       <= 1'b0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= |r_gnt;
      if (|r_gnt) begin
        r_dout <= din[r_sel];
      end

      if (w_take) begin
        r_state <= S_GRANT;
        r_gnt   <= 4'b0001 << w_win;
        r_sel   <= w_win;
        r_ptr   <= w_win + 2'd1;
        r_cnt   <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: ;
          S_GRANT: begin
            if (!w_owner_req) begin
              r_state <= S_IDLE;
              r_gnt   <= '0;
              r_cnt   <= '0;
            end else if (!w_cnt_last) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
          end
        endcase
      end
    end
  end

  assign gnt        = r_gnt;
  assign sel        = r_sel;
  assign busy       = |r_gnt;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

- Round-robin arbiter and sequencer that shares one 4:1 single-bit multiplexer path among four requesters.
- Accepts per-requester level requests and issues a one-hot grant plus a matching 2-bit mux select.
- Enforces a bounded hold time so no requester can monopolise the path while others wait.
- Registers the selected data bit with a valid flag for downstream consumers; sits between requester logic and the shared mux/consumer.

## Interface
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while another request is pending; legal range 1..256.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- req  input  4  level request per requester; bit i high = requester i wants the path.
- din  input  4  data bits; din[i] belongs to requester i (mux inputs in0..in3).
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered encoded owner index driven to the mux select.
- busy  output  1  equals |gnt.
- dout  output  1  registered din[sel] sampled while granted.
- dout_valid  output  1  high the cycle after a granted cycle.

## Operation
- State is IDLE (gnt = 0) or GRANT(o) (gnt = 1<<o, sel = o).
- Internal state: ptr (2 bits) is the first index considered; cnt is the hold counter, width clog2(MAX_HOLD), minimum 1 bit.
- Arbitration function pick(mask): scans indices ptr, ptr+1, ptr+2, ptr+3 (mod 4) and returns the first index with mask bit set.
- IDLE:
  - if req != 0, go to GRANT(pick(req)); cnt = 0; ptr = winner+1 mod 4.
  - otherwise stay in IDLE; ptr, sel and cnt unchanged.
- GRANT(o), evaluated each cycle; let others = req & ~(1<<o).
  - Release (req[o] == 0):
    - if others != 0, go directly to GRANT(pick(others)) with no idle bubble.
    - else go to IDLE.
    - On either path, ptr = new winner+1 (unchanged if idle); cnt = 0.
  - Preempt (req[o] == 1, cnt == MAX_HOLD-1, others != 0): go to GRANT(pick(others)); cnt = 0; ptr = winner+1.
  - Continue (any other case): stay in GRANT(o). cnt increments, saturating at MAX_HOLD-1. With no contender the owner keeps the grant indefinitely.
- sel holds the last owner through IDLE; it changes only when a new grant is issued.
- Data path:
  - dout = din[o] registered each cycle gnt is high; dout_valid = registered busy.
  - dout holds its last value when dout_valid is low.
- Simultaneous events:
  - New requests arriving in the same cycle as a release or preempt are eligible in that same arbitration.
  - The releasing owner is excluded from that arbitration even if it re-raises req the next cycle.
- Reset (any cycle, including mid-grant): next edge forces gnt = 0, sel = 0, busy = 0, dout = 0, dout_valid = 0, ptr = 0, cnt = 0, state IDLE. req is ignored in the reset cycle.

## Timing
- Reset values: gnt 4'b0000, sel 2'b00, busy 0, dout 0, dout_valid 0.
- Request to grant: req sampled high in cycle k, gnt/sel valid in cycle k+1 (1-cycle latency from idle).
- Handoff: owner drops req in cycle k, new owner granted in cycle k+1; gnt never has two bits set and never shows a zero cycle when a contender waits.
- Preemption: owner granted first in cycle g, contended throughout, loses grant in cycle g+MAX_HOLD.
- Data: gnt high in cycle k, dout = din[sel] captured at end of k, visible in cycle k+1 with dout_valid = 1.
- Worst-case wait for a continuously requesting index: 3*MAX_HOLD cycles after its req rises, plus 1.

## Test plan
- Reset and idle: rst for 2 cycles, then req = 0 for 5 cycles -> gnt = 0, sel = 0, busy = 0, dout_valid = 0 throughout.
- Single request: req = 4'b0100 from cycle 3 -> gnt = 4'b0100, sel = 2 from cycle 4. din[2] = 1 in cycle 4 gives dout = 1, dout_valid = 1 in cycle 5. Drop req in cycle 8 -> gnt = 0 in cycle 9.
- Round-robin, MAX_HOLD = 8: req = 4'b1111, each owner drops req after 2 granted cycles then re-raises -> grant order 0, 1, 2, 3, 0, with no idle cycles between owners.
- Preemption, MAX_HOLD = 3: req = 4'b0011 held constant -> owner 0 for 3 cycles, owner 1 for 3, owner 0 for 3, and so on. With req = 4'b0001 only, owner 0 holds for 20+ cycles.
- Simultaneous release and arrival: owner 1 drops req in the same cycle req[3] and req[0] rise, with ptr = 2 -> next grant goes to 3, not 0.
- Mid-grant reset: owner 2 granted with cnt = 4, assert rst for 1 cycle -> next cycle all outputs 0, ptr = 0. With req = 4'b1100 held, the first grant after reset goes to 2.
